exp6_fluxo_dados: RTL and testbench

Datapath for the memory-sequence game. It receives the Moore control strobes issued by the game control unit (zera/conta/registra/ativa) and returns every condition flag that unit branches on. It holds the address and round counters, the show and play timers, the sequence ROM, the player-move register, the level register and the button edge detector, and it drives the LEDs.

---
 rtl/exp6_pkg.sv | 16 +
 rtl/exp6_fluxo_dados_rom.sv | 11 +
 rtl/exp6_fluxo_dados.sv | 156 +++++++++++++++
 tb/tb_exp6_fluxo_dados.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exp6_pkg.sv
// Shared constants and sequence ROM contents for the exp6 memory-sequence game datapath.
package exp6_pkg;

  localparam int unsigned END_W        = 4;
  localparam int unsigned DADO_W       = 4;
  localparam int unsigned ROM_PROF     = 16;
  localparam int unsigned MEIO_RODADAS = 7;
  localparam int unsigned FIM_RODADAS  = 15;

  // Sequence words; element [k] is the word stored at address k.
  localparam logic [ROM_PROF-1:0][DADO_W-1:0] ROM_CONTEUDO = {
    4'd4, 4'd1, 4'd8, 4'd8, 4'd4, 4'd4, 4'd2, 4'd2,
    4'd1, 4'd1, 4'd2, 4'd4, 4'd8, 4'd4, 4'd2, 4'd1
  };

endpackage

// File: rtl/exp6_fluxo_dados_rom.sv
// Asynchronous-read 16x4 sequence ROM addressed by the address counter.
module exp6_rom_16x4
  import exp6_pkg::*;
(
  input  logic [END_W-1:0]  endereco,
  output logic [DADO_W-1:0] dado
);

  assign dado = ROM_CONTEUDO[endereco];

endmodule

// File: rtl/exp6_fluxo_dados.sv
// Datapath for the memory-sequence game: counters, timers, sequence ROM,
// move/level registers, button edge detector and LED drive.
// Optional build macro EXP6_SYNC_BOTOES_EN adds a 2-flop button synchronizer.
module exp6_fluxo_dados
  import exp6_pkg::*;
#(
  parameter int unsigned TM_CICLOS    = 1000,
  parameter int unsigned TEMPO_CICLOS = 5000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              zeraC,
  input  logic              contaC,
  input  logic              zeraCR,
  input  logic              contaCR,
  input  logic              zeraTM,
  input  logic              contaTM,
  input  logic              zeraTempo,
  input  logic              contaTempo,
  input  logic              zeraR,
  input  logic              registraR,
  input  logic              registraN,
  input  logic              ativa_leds,
  input  logic [3:0]        botoes,
  input  logic              nivel_tempo_in,
  input  logic              nivel_jogadas_in,
  output logic              fimC,
  output logic              fimCR,
  output logic              meioCR,
  output logic              fimTM,
  output logic              meioTM,
  output logic              fimTempo,
  output logic              meioTempo,
  output logic              enderecoIgualRodada,
  output logic              jogada_feita,
  output logic              jogada_correta,
  output logic              nivel_tempo,
  output logic              nivel_jogadas,
  output logic [3:0]        leds,
  output logic [3:0]        db_contagem,
  output logic [3:0]        db_rodada,
  output logic [3:0]        db_jogada,
  output logic [3:0]        db_memoria
);

  localparam int unsigned TM_W    = $clog2(TM_CICLOS);
  localparam int unsigned TEMPO_W = $clog2(TEMPO_CICLOS);

  localparam logic [TM_W-1:0]    TM_FIM     = TM_W'(TM_CICLOS - 1);
  localparam logic [TM_W-1:0]    TM_MEIO    = TM_W'(TM_CICLOS / 2 - 1);
  localparam logic [TEMPO_W-1:0] TEMPO_FIM  = TEMPO_W'(TEMPO_CICLOS - 1);
  localparam logic [TEMPO_W-1:0] TEMPO_MEIO = TEMPO_W'(TEMPO_CICLOS / 2 - 1);

  logic [END_W-1:0]   contagem;
  logic [END_W-1:0]   rodada;
  logic [TM_W-1:0]    tm;
  logic [TEMPO_W-1:0] tempo;
  logic [DADO_W-1:0]  jogada;
  logic [DADO_W-1:0]  dadoMemoria;
  logic [3:0]         botoesS;
  logic               prev;

`ifdef EXP6_SYNC_BOTOES_EN
  logic [3:0] botoesMeta;
  logic [3:0] botoesSinc;

  // Two-flop synchronizer for the asynchronous player buttons
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      botoesMeta <= '0;
      botoesSinc <= '0;
    end else begin
      botoesMeta <= botoes;
      botoesSinc <= botoesMeta;
    end
  end

  assign botoesS = botoesSinc;
`else
  assign botoesS = botoes;
`endif

  // Address counter, wraps naturally at 15
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       contagem <= '0;
    else if (zeraC)  contagem <= '0;
    else if (contaC) contagem <= contagem + END_W'(1);
  end

  // Round counter, wraps naturally at 15
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        rodada <= '0;
    else if (zeraCR)  rodada <= '0;
    else if (contaCR) rodada <= rodada + END_W'(1);
  end

  // Show timer wraps so the control unit can keep counting into the off gap
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        tm <= '0;
    else if (zeraTM)  tm <= '0;
    else if (contaTM) tm <= (tm == TM_FIM) ? '0 : tm + TM_W'(1);
  end

  // Play timer saturates so its end/half flags stay asserted
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                               tempo <= '0;
    else if (zeraTempo)                      tempo <= '0;
    else if (contaTempo && tempo != TEMPO_FIM) tempo <= tempo + TEMPO_W'(1);
  end

  // Player move register
  always_ff @(posedge clock or posedge reset) begin
    if (reset)          jogada <= '0;
    else if (zeraR)     jogada <= '0;
    else if (registraR) jogada <= botoesS;
  end

  // Level register, cleared only by reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      nivel_tempo   <= 1'b0;
      nivel_jogadas <= 1'b0;
    end else if (registraN) begin
      nivel_tempo   <= nivel_tempo_in;
      nivel_jogadas <= nivel_jogadas_in;
    end
  end

  // Previous any-button-pressed state for the press edge detector
  always_ff @(posedge clock or posedge reset) begin
    if (reset) prev <= 1'b0;
    else       prev <= |botoesS;
  end

  exp6_rom_16x4 u_rom (
    .endereco (contagem),
    .dado     (dadoMemoria)
  );

  assign fimC                = (contagem == END_W'(FIM_RODADAS));
  assign fimCR               = (rodada == END_W'(FIM_RODADAS));
  assign meioCR              = (rodada == END_W'(MEIO_RODADAS));
  assign fimTM               = (tm == TM_FIM);
  assign meioTM              = (tm == TM_MEIO);
  assign fimTempo            = (tempo == TEMPO_FIM);
  assign meioTempo           = (tempo >= TEMPO_MEIO);
  assign enderecoIgualRodada = (contagem == rodada);
  assign jogada_feita        = (|botoesS) & ~prev;
  assign jogada_correta      = (dadoMemoria == jogada);
  assign leds                = ativa_leds ? dadoMemoria : botoesS;
  assign db_contagem         = contagem;
  assign db_rodada           = rodada;
  assign db_jogada           = jogada;
  assign db_memoria          = dadoMemoria;

endmodule

// File: tb/tb_exp6_fluxo_dados.sv
// Scoreboard bench for exp6_fluxo_dados with TM_CICLOS=4, TEMPO_CICLOS=8.
module tb_exp6_fluxo_dados;

  localparam int unsigned TM_CICLOS    = 4;
  localparam int unsigned TEMPO_CICLOS = 8;
`ifdef EXP6_SYNC_BOTOES_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  localparam int S_FIMC = 0, S_FIMCR = 1, S_MEIOCR = 2, S_FIMTM = 3, S_MEIOTM = 4;
  localparam int S_FIMTEMPO = 5, S_MEIOTEMPO = 6, S_IGUAL = 7, S_FEITA = 8;
  localparam int S_CORRETA = 9, S_NTEMPO = 10, S_NJOGADAS = 11, S_LEDS = 12;
  localparam int S_CONTAGEM = 13, S_RODADA = 14, S_JOGADA = 15, S_MEMORIA = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic zeraC = 0, contaC = 0, zeraCR = 0, contaCR = 0, zeraTM = 0, contaTM = 0;
  logic zeraTempo = 0, contaTempo = 0, zeraR = 0, registraR = 0, registraN = 0;
  logic ativa_leds = 0, nivel_tempo_in = 0, nivel_jogadas_in = 0;
  logic [3:0] botoes = 4'd0;
  logic fimC, fimCR, meioCR, fimTM, meioTM, fimTempo, meioTempo;
  logic enderecoIgualRodada, jogada_feita, jogada_correta, nivel_tempo, nivel_jogadas;
  logic [3:0] leds, db_contagem, db_rodada, db_jogada, db_memoria;

  exp6_fluxo_dados #(.TM_CICLOS(TM_CICLOS), .TEMPO_CICLOS(TEMPO_CICLOS)) dut (
    .clock(clock), .reset(reset),
    .zeraC(zeraC), .contaC(contaC), .zeraCR(zeraCR), .contaCR(contaCR),
    .zeraTM(zeraTM), .contaTM(contaTM), .zeraTempo(zeraTempo), .contaTempo(contaTempo),
    .zeraR(zeraR), .registraR(registraR), .registraN(registraN), .ativa_leds(ativa_leds),
    .botoes(botoes), .nivel_tempo_in(nivel_tempo_in), .nivel_jogadas_in(nivel_jogadas_in),
    .fimC(fimC), .fimCR(fimCR), .meioCR(meioCR), .fimTM(fimTM), .meioTM(meioTM),
    .fimTempo(fimTempo), .meioTempo(meioTempo), .enderecoIgualRodada(enderecoIgualRodada),
    .jogada_feita(jogada_feita), .jogada_correta(jogada_correta),
    .nivel_tempo(nivel_tempo), .nivel_jogadas(nivel_jogadas), .leds(leds),
    .db_contagem(db_contagem), .db_rodada(db_rodada), .db_jogada(db_jogada),
    .db_memoria(db_memoria)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      nome;
    int         sel;
    logic [3:0] valor;
  } esperado_t;

  esperado_t fila[$];
  int nAssert = 0;
  int nFail   = 0;

  function automatic logic [3:0] leSinal(int sel);
    case (sel)
      S_FIMC:      return {3'b0, fimC};
      S_FIMCR:     return {3'b0, fimCR};
      S_MEIOCR:    return {3'b0, meioCR};
      S_FIMTM:     return {3'b0, fimTM};
      S_MEIOTM:    return {3'b0, meioTM};
      S_FIMTEMPO:  return {3'b0, fimTempo};
      S_MEIOTEMPO: return {3'b0, meioTempo};
      S_IGUAL:     return {3'b0, enderecoIgualRodada};
      S_FEITA:     return {3'b0, jogada_feita};
      S_CORRETA:   return {3'b0, jogada_correta};
      S_NTEMPO:    return {3'b0, nivel_tempo};
      S_NJOGADAS:  return {3'b0, nivel_jogadas};
      S_LEDS:      return leds;
      S_CONTAGEM:  return db_contagem;
      S_RODADA:    return db_rodada;
      S_JOGADA:    return db_jogada;
      default:     return db_memoria;
    endcase
  endfunction

  // Monitor: outputs are stable mid-cycle; drain every pending expectation
  always @(negedge clock) begin : monitor
    esperado_t e;
    while (fila.size() > 0) begin
      e = fila.pop_front();
      nAssert++;
      if (leSinal(e.sel) !== e.valor) begin
        nFail++;
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", e.nome, leSinal(e.sel), e.valor, $time);
      end
    end
  end

  task automatic ciclo(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic espera(input string nome, input int sel, input logic [3:0] v);
    esperado_t e;
    e.nome  = nome;
    e.sel   = sel;
    e.valor = v;
    fila.push_back(e);
  endtask

  task automatic esperaReset(input string tag);
    espera({tag, "_fimC"}, S_FIMC, 4'd0);
    espera({tag, "_fimCR"}, S_FIMCR, 4'd0);
    espera({tag, "_meioCR"}, S_MEIOCR, 4'd0);
    espera({tag, "_fimTM"}, S_FIMTM, 4'd0);
    espera({tag, "_meioTM"}, S_MEIOTM, 4'd0);
    espera({tag, "_fimTempo"}, S_FIMTEMPO, 4'd0);
    espera({tag, "_meioTempo"}, S_MEIOTEMPO, 4'd0);
    espera({tag, "_igual"}, S_IGUAL, 4'd1);
    espera({tag, "_feita"}, S_FEITA, 4'd0);
    espera({tag, "_correta"}, S_CORRETA, 4'd0);
    espera({tag, "_nTempo"}, S_NTEMPO, 4'd0);
    espera({tag, "_nJogadas"}, S_NJOGADAS, 4'd0);
    espera({tag, "_contagem"}, S_CONTAGEM, 4'd0);
    espera({tag, "_rodada"}, S_RODADA, 4'd0);
    espera({tag, "_jogada"}, S_JOGADA, 4'd0);
    espera({tag, "_memoria"}, S_MEMORIA, 4'd1);
    espera({tag, "_leds"}, S_LEDS, 4'd0);
  endtask

  initial begin
    // 1: reset and idle
    ciclo(2);
    reset = 1'b0;
    ciclo(2);
    esperaReset("rst");

    // 2: address counter and ROM
    contaC = 1; ciclo(3); contaC = 0;
    espera("c3_contagem", S_CONTAGEM, 4'd3);
    espera("c3_memoria", S_MEMORIA, 4'd8);
    ativa_leds = 1;
    espera("c3_leds", S_LEDS, 4'd8);
    ciclo(1);
    ativa_leds = 0;
    espera("c3_hold", S_CONTAGEM, 4'd3);
    contaC = 1; ciclo(12); contaC = 0;
    espera("c15_fimC", S_FIMC, 4'd1);
    espera("c15_memoria", S_MEMORIA, 4'd4);
    contaC = 1; ciclo(1); contaC = 0;
    espera("cwrap_contagem", S_CONTAGEM, 4'd0);
    espera("cwrap_fimC", S_FIMC, 4'd0);
    contaC = 1; ciclo(1);
    zeraC = 1; ciclo(1); zeraC = 0; contaC = 0;
    espera("czera_prio", S_CONTAGEM, 4'd0);

    // 3: show timer with wrap and zera priority
    contaTM = 1;
    ciclo(1); espera("tm1_meio", S_MEIOTM, 4'd1); espera("tm1_fim", S_FIMTM, 4'd0);
    ciclo(1); espera("tm2_meio", S_MEIOTM, 4'd0); espera("tm2_fim", S_FIMTM, 4'd0);
    ciclo(1); espera("tm3_fim", S_FIMTM, 4'd1); espera("tm3_meio", S_MEIOTM, 4'd0);
    ciclo(1); espera("tm0_fim", S_FIMTM, 4'd0); espera("tm0_meio", S_MEIOTM, 4'd0);
    ciclo(1); espera("tm1b_meio", S_MEIOTM, 4'd1);
    ciclo(1); espera("tm2b_meio", S_MEIOTM, 4'd0);
    zeraTM = 1; ciclo(1); zeraTM = 0;
    espera("tmzera_fim", S_FIMTM, 4'd0);
    ciclo(1); espera("tmzera_next_meio", S_MEIOTM, 4'd1);
    contaTM = 0; ciclo(1);
    espera("tm_hold_meio", S_MEIOTM, 4'd1);
    zeraTM = 1; ciclo(1); zeraTM = 0;

    // 4: play timer saturation
    contaTempo = 1;
    for (int i = 1; i <= 7; i++) begin
      ciclo(1);
      espera($sformatf("tempo%0d_meio", i), S_MEIOTEMPO, (i >= 3) ? 4'd1 : 4'd0);
      espera($sformatf("tempo%0d_fim", i), S_FIMTEMPO, (i == 7) ? 4'd1 : 4'd0);
    end
    for (int i = 0; i < 5; i++) begin
      ciclo(1);
      espera($sformatf("tempo_sat%0d_fim", i), S_FIMTEMPO, 4'd1);
      espera($sformatf("tempo_sat%0d_meio", i), S_MEIOTEMPO, 4'd1);
    end
    zeraTempo = 1; ciclo(1); zeraTempo = 0; contaTempo = 0;
    espera("tempo_zera_fim", S_FIMTEMPO, 4'd0);
    espera("tempo_zera_meio", S_MEIOTEMPO, 4'd0);

    // 5: button edge detect and move register
    contaC = 1; ciclo(2); contaC = 0;
    espera("c2_memoria", S_MEMORIA, 4'd4);
    botoes = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      espera($sformatf("feita%0d", i), S_FEITA, (i == LAT) ? 4'd1 : 4'd0);
      espera($sformatf("ledsbot%0d", i), S_LEDS, (i >= LAT) ? 4'd4 : 4'd0);
      ciclo(1);
    end
    registraR = 1; ciclo(1); registraR = 0;
    espera("reg4_jogada", S_JOGADA, 4'd4);
    espera("reg4_correta", S_CORRETA, 4'd1);
    botoes = 4'b0001;
    ciclo(LAT);
    registraR = 1; ciclo(1); registraR = 0;
    espera("reg1_jogada", S_JOGADA, 4'd1);
    espera("reg1_correta", S_CORRETA, 4'd0);
    espera("reg1_feita", S_FEITA, 4'd0);
    zeraR = 1; registraR = 1; ciclo(1); zeraR = 0; registraR = 0;
    espera("zeraR_jogada", S_JOGADA, 4'd0);
    botoes = 4'b0000;
    ciclo(LAT + 1);

    // 6: rounds, compare, level register, async reset
    contaCR = 1; ciclo(7); contaCR = 0;
    espera("cr7_meio", S_MEIOCR, 4'd1);
    espera("cr7_rodada", S_RODADA, 4'd7);
    espera("cr7_fim", S_FIMCR, 4'd0);
    zeraC = 1; ciclo(1); zeraC = 0;
    espera("igual_nao", S_IGUAL, 4'd0);
    contaC = 1; ciclo(7); contaC = 0;
    espera("igual_sim", S_IGUAL, 4'd1);
    espera("c7_contagem", S_CONTAGEM, 4'd7);
    nivel_tempo_in = 1; nivel_jogadas_in = 1; registraN = 1;
    ciclo(1);
    registraN = 0; nivel_tempo_in = 0; nivel_jogadas_in = 0;
    espera("nivel_tempo", S_NTEMPO, 4'd1);
    espera("nivel_jogadas", S_NJOGADAS, 4'd1);
    ciclo(1);
    espera("nivel_hold", S_NTEMPO, 4'd1);
    contaCR = 1; ciclo(8);
    espera("cr15_fim", S_FIMCR, 4'd1);
    espera("cr15_meio", S_MEIOCR, 4'd0);
    espera("cr15_rodada", S_RODADA, 4'd15);
    ciclo(1);
    espera("crwrap_rodada", S_RODADA, 4'd0);
    ciclo(1);
    reset = 1;
    esperaReset("rstmid");
    ciclo(1);
    reset = 0; contaCR = 0;
    ciclo(1);

    @(negedge clock);
    #1;
    nAssert++;
    if (fila.size() != 0) begin
      nFail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", fila.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
